// File: rtl/isa_pkg.sv
// Instruction-set field layout shared by the encoder and the decoder.
// Bit positions are the single source of truth for the 16-bit word format.
package isa_pkg;

  localparam int INSTR_WIDTH = 16;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int FLAG_BIT = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = RA_MSB - 2;
  localparam int RB_MSB   = 4;
  localparam int RB_LSB   = RB_MSB - 2;
  localparam int IMM_MSB  = 7;

  typedef enum logic {
    FORM_REG = 1'b0,
    FORM_IMM = 1'b1
  } form_e;

  function automatic logic [INSTR_WIDTH-1:0] encode_word(
    input logic [3:0] opc,
    input logic [2:0] rd,
    input logic       fl,
    input logic [2:0] ra,
    input logic [2:0] rb,
    input logic [7:0] imm,
    input form_e      form
  );
    logic [INSTR_WIDTH-1:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = opc;
    w[RD_MSB:RD_LSB]   = rd;
    w[FLAG_BIT]        = fl;
    if (form == FORM_IMM) begin
      w[IMM_MSB:0] = imm;
    end else begin
      w[RA_MSB:RA_LSB] = ra;
      w[RB_MSB:RB_LSB] = rb;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and full/empty flags.
// Reset clears pointers and count; stored data is simply abandoned.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs instruction fields into 16-bit words, buffers them, and presents
// them downstream with a sequential instruction address.
module instruction_encoder
  import isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   opcode,
  input  logic [2:0]                   rDadrs,
  input  logic [2:0]                   rAadrs,
  input  logic [2:0]                   rBadrs,
  input  logic [7:0]                   imm,
  input  logic                         flag,
  input  logic                         imm_form,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       instruct,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  input  logic                         addr_load,
  input  logic [ADDR_WIDTH-1:0]        addr_value,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         addr_wrap
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  logic [INSTR_WIDTH-1:0] enc_word;
  logic [INSTR_WIDTH-1:0] head_word;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign enc_word = encode_word(opcode, rDadrs, flag, rAadrs, rBadrs, imm,
                                form_e'(imm_form));

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign instruct  = out_valid ? head_word : '0;

  sync_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (enc_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // A load overrides the increment, so a coincident pop cannot flag a wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_addr  <= '0;
      addr_wrap <= 1'b0;
    end else if (addr_load) begin
      out_addr <= addr_value;
    end else if (pop) begin
      out_addr <= out_addr + ADDR_WIDTH'(1);
      if (out_addr == ADDR_MAX) addr_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encoding vectors from a table,
// then hand-written sequences for back-pressure, wrap/load and reset.
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  rDadrs;
  logic [2:0]  rAadrs;
  logic [2:0]  rBadrs;
  logic [7:0]  imm;
  logic        flag;
  logic        imm_form;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instruct;
  logic [7:0]  out_addr;
  logic        addr_load;
  logic [7:0]  addr_value;
  logic [2:0]  count;
  logic        addr_wrap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  instruction_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rDadrs     (rDadrs),
    .rAadrs     (rAadrs),
    .rBadrs     (rBadrs),
    .imm        (imm),
    .flag       (flag),
    .imm_form   (imm_form),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instruct   (instruct),
    .out_addr   (out_addr),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .count      (count),
    .addr_wrap  (addr_wrap)
  );

  typedef struct {
    logic [3:0]  opc;
    logic [2:0]  rd;
    logic        fl;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [7:0]  im;
    logic        form;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] fill_words[5];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] o, input logic [2:0] d, input logic f,
                            input logic [2:0] a, input logic [2:0] b,
                            input logic [7:0] i, input logic fm);
    opcode = o; rDadrs = d; flag = f; rAadrs = a; rBadrs = b; imm = i; imm_form = fm;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // opc, rD, flag, rA, rB, imm, form, expected word
    vecs[0] = '{4'h3, 3'd5, 1'b1, 3'd2, 3'd6, 8'hFF, 1'b0, 16'h3B58};
    vecs[1] = '{4'h8, 3'd1, 1'b0, 3'd7, 3'd7, 8'hA5, 1'b1, 16'h82A5};
    vecs[2] = '{4'hF, 3'd7, 1'b1, 3'd7, 3'd7, 8'h00, 1'b0, 16'hFFFC};
    vecs[3] = '{4'h0, 3'd0, 1'b0, 3'd5, 3'd5, 8'h00, 1'b1, 16'h0000};
    vecs[4] = '{4'hA, 3'd2, 1'b1, 3'd0, 3'd0, 8'h3C, 1'b1, 16'hA53C};
    fill_words[0] = 16'h1010;
    fill_words[1] = 16'h2211;
    fill_words[2] = 16'h3412;
    fill_words[3] = 16'h4613;
    fill_words[4] = 16'h5814;

    in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; addr_value = '0;
    set_fields(4'h0, 3'd0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
    do_reset();

    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instruct", 32'(instruct), 32'h0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_addr_wrap", 32'(addr_wrap), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table: push one word, check it one edge later, then pop it.
    for (int i = 0; i < 5; i++) begin
      set_fields(vecs[i].opc, vecs[i].rd, vecs[i].fl, vecs[i].ra, vecs[i].rb,
                 vecs[i].im, vecs[i].form);
      in_valid = 1'b1;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      set_fields(4'h0, 3'd0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_word", i), 32'(instruct), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(i));
      check($sformatf("vec%0d_count", i), 32'(count), 32'd1);
      step();
      check($sformatf("vec%0d_hold_word", i), 32'(instruct), 32'(vecs[i].exp_word));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("vec%0d_addr_after_pop", i), 32'(out_addr), 32'(i + 1));
      check($sformatf("vec%0d_empty_word", i), 32'(instruct), 32'h0);
    end

    // Back-pressure fill: 4 accepted, 5th held off while full.
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_fields(4'(k + 1), 3'(k), 1'b0, 3'd0, 3'd0, 8'(8'h10 + k), 1'b1);
      step();
      check($sformatf("fill%0d_count", k), 32'(count), 32'(k + 1));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    set_fields(4'h5, 3'd4, 1'b0, 3'd0, 3'd0, 8'h14, 1'b1);
    step();
    check("full_5th_rejected", 32'(count), 32'd4);
    check("full_head_word", 32'(instruct), 32'(fill_words[0]));
    check("full_head_addr", 32'(out_addr), 32'd0);

    // Full with push and pop requested: only the pop happens.
    out_ready = 1'b1;
    step();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_addr", 32'(out_addr), 32'd1);
    check("fullpop_word", 32'(instruct), 32'(fill_words[1]));
    step();
    in_valid = 1'b0;
    check("pushpop_count", 32'(count), 32'd3);
    check("pushpop_addr", 32'(out_addr), 32'd2);
    check("pushpop_word", 32'(instruct), 32'(fill_words[2]));
    for (int k = 3; k < 5; k++) begin
      step();
      check($sformatf("drain%0d_addr", k), 32'(out_addr), 32'(k));
      check($sformatf("drain%0d_word", k), 32'(instruct), 32'(fill_words[k]));
    end
    step();
    out_ready = 1'b0;
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_count", 32'(count), 32'd0);

    // Address load near the top, then pops through the wrap.
    addr_load = 1'b1; addr_value = 8'hFE;
    step();
    addr_load = 1'b0;
    check("load_addr", 32'(out_addr), 32'hFE);
    check("load_no_wrap", 32'(addr_wrap), 32'd0);
    in_valid = 1'b1;
    set_fields(4'h1, 3'd1, 1'b1, 3'd1, 3'd1, 8'h00, 1'b0);
    repeat (3) step();
    in_valid = 1'b0;
    check("wrapfill_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    step();
    check("wrap_addr_ff", 32'(out_addr), 32'hFF);
    check("wrap_flag_pre", 32'(addr_wrap), 32'd0);
    step();
    check("wrap_addr_00", 32'(out_addr), 32'h00);
    check("wrap_flag_set", 32'(addr_wrap), 32'd1);
    step();
    check("wrap_addr_01", 32'(out_addr), 32'h01);
    check("wrap_flag_sticky", 32'(addr_wrap), 32'd1);
    out_ready = 1'b0;

    // Load coincident with a pop: loaded value wins, pop still completes.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    addr_load = 1'b1; addr_value = 8'h40; out_ready = 1'b1;
    step();
    addr_load = 1'b0; out_ready = 1'b0;
    check("loadpop_addr", 32'(out_addr), 32'h40);
    check("loadpop_count", 32'(count), 32'd0);

    // Reset with three words buffered.
    in_valid = 1'b1;
    set_fields(4'h7, 3'd3, 1'b1, 3'd0, 3'd0, 8'h99, 1'b1);
    repeat (3) step();
    in_valid = 1'b0;
    check("prerst_count", 32'(count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_instruct", 32'(instruct), 32'h0);
    check("midrst_addr", 32'(out_addr), 32'd0);
    check("midrst_wrap", 32'(addr_wrap), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
